imem_loader: RTL and testbench
==============================

# imem_loader

Boot loader that sits directly upstream of the `cpu` top. It accepts a stream of instruction words over a valid/ready handshake and writes them into the CPU's instruction memory through the external port (`addr_ext`/`wen_ext`/`wdata_ext`). It then, optionally, reads the image back to verify it. Finally it raises the CPU `enable` so the pipeline starts fetching from the loaded image.

## Interface

Parameters:
- `ADDR_W`, 9: instruction memory word-address width; max image = 2^ADDR_W words.
- `BASE_ADDR`, 32'h0: byte address of the first loaded word.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load; sampled only in IDLE, RUN and FAIL.
- `abort` in 1: synchronous; returns to IDLE from any state.
- `num_words` in ADDR_W+1: image length in words; sampled on `start`.
- `in_valid` in 1: `in_data` valid.
- `in_data` in 32: instruction word.
- `in_ready` out 1: loader accepts a word this cycle.
- `addr_ext` out 32: instruction memory external address; byte address.
- `wen_ext` out 1: instruction memory external write enable.
- `ren_ext` out 1: instruction memory external read enable.
- `wdata_ext` out 32: instruction memory external write data.
- `rdata_ext` in 32: instruction memory external read data; valid one cycle after `ren_ext`.
- `cpu_enable` out 1: drives the `cpu` `enable` input.
- `busy` out 1: a load or verify is in progress.
- `done` out 1: image is loaded and the CPU is running.
- `error` out 1: length or verify failure.
- `checksum` out 32: XOR of all words accepted in the current load.

## Operation

States: IDLE, LOAD, LOAD_END, VERIFY (macro only), RUN, FAIL.

- **IDLE**
  - `start` with `num_words`==0 -> RUN.
  - `start` with `num_words` > 2^ADDR_W -> FAIL.
  - Otherwise `start` -> LOAD. On entry, the word index and `checksum` clear to 0 and `num_words` is latched.
- **LOAD**
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) registers one write: next cycle `wen_ext`=1, `addr_ext`=BASE_ADDR+4*idx, `wdata_ext`=`in_data`.
  - On each handshake, `checksum` ^= `in_data` and idx increments.
  - The handshake of word `num_words`-1 -> LOAD_END.
  - Bubbles (`in_valid`=0) stall with no writes.
- **LOAD_END**
  - One cycle. `in_ready`=0 and the last write is on the bus.
  - Next state is VERIFY if the macro is defined, else RUN.
- **RUN**
  - `cpu_enable`=1, `done`=1, `busy`=0.
  - `start` -> LOAD (or RUN if length 0, or FAIL if too long); `cpu_enable` drops the next cycle.
- **FAIL**
  - `error`=1, `cpu_enable`=0.
  - Left only by `start` (same rules as IDLE) or `abort`.
- **abort**: from any state -> IDLE next cycle. All strobes drop; the memory contents already written are left as they are.
- `busy`=1 in LOAD, LOAD_END and VERIFY.
- `in_ready`=0 outside LOAD.
- `wen_ext` and `ren_ext` are never high in the same cycle.
- `in_data` is never written when `in_ready`=0.
- Address wraps are impossible: the length check guarantees idx < 2^ADDR_W.

## Timing

- Reset: state IDLE; all outputs 0; `addr_ext`=0.
- All outputs are registered except `in_ready`, which is decoded from the state register.
- Write latency: handshake in cycle T -> `wen_ext` in T+1.
- A load of N words with no bubbles:
  - Last handshake at cycle T0+N (LOAD entered at T0+1).
  - LOAD_END in T0+N+1.
  - Without the macro, `cpu_enable`=1 from T0+N+2.
- VERIFY:
  - Issues reads back-to-back: `ren_ext`=1 for N cycles, addresses ascending.
  - Each `rdata_ext` is XORed into a verify accumulator one cycle later.
  - Occupies N+1 cycles, then compares the accumulator with `checksum`: equal -> RUN, else FAIL.
- Back-to-back handshakes sustain one word per cycle.
- `start` in the same cycle as `abort`: `abort` wins.

## Configuration

- `IMEM_LOADER_VERIFY_EN` defined:
  - VERIFY state, read-back and compare are compiled in.
  - `ren_ext` is used.
  - A mismatch -> FAIL with `error`=1 and `cpu_enable`=0.
- Not defined:
  - VERIFY is absent; LOAD_END -> RUN.
  - `ren_ext` is tied 0 and `rdata_ext` is ignored.
  - `error` can only come from the length check.

## Test plan

- Reset mid-LOAD, then release: all outputs 0 and state IDLE; a fresh `start` with `num_words`=3 loads 3 words at 0x0, 0x4, 0x8.
- `start`, `num_words`=4, words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 streamed with no bubbles: four `wen_ext` pulses at byte addresses 0,4,8,12 on consecutive cycles; `checksum`=XOR of the four words; `cpu_enable`=1 two cycles after the last handshake (macro off).
- Same load with `in_valid` toggling every other cycle: identical memory writes and `checksum`; writes are spaced 2 cycles apart.
- `num_words`=513 with ADDR_W=9: FAIL next cycle, `error`=1, no `wen_ext`. Then `start` with `num_words`=0: RUN immediately.
- Macro on, 8-word load with a memory model that corrupts word 5 on read: 8 `ren_ext` cycles, then FAIL, `error`=1, `cpu_enable`=0. Without corruption: RUN.
- `abort` in the cycle after the second of 4 handshakes: IDLE next cycle, `in_ready`=0, `busy`=0, `cpu_enable`=0. The second word's write still completes; no further writes.

Source files
------------

// File: rtl/imem_loader_if.sv
// Stream and instruction-memory bus between the boot loader and its neighbours.
// master = loader side; slave = stream source plus memory side.
interface imem_loader_if;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic [31:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [31:0] rdata_ext;

   modport master (
      input  in_valid, in_data, rdata_ext,
      output in_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );

   modport slave (
      output in_valid, in_data, rdata_ext,
      input  in_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: streams words into instruction memory, optionally reads back (IMEM_LOADER_VERIFY_EN), then enables the CPU.
// Latency: write one cycle after each handshake; cpu_enable two cycles after the last handshake without verify.
// Backpressure: in_ready only in LOAD, one word per cycle, no internal buffering.
module imem_loader #(
   parameter int unsigned ADDR_W    = 9,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_words,
   imem_loader_if.master     bus,
   output logic              cpu_enable,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       checksum
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOAD_END,
`ifdef IMEM_LOADER_VERIFY_EN
      S_VERIFY,
`endif
      S_RUN,
      S_FAIL
   } state_t;

   state_t          state, state_nxt;
   logic [ADDR_W:0] idx, idx_nxt;
   logic [ADDR_W:0] len, len_nxt;
   logic [31:0]     csum_q, csum_nxt;
   logic [31:0]     addr_q, addr_nxt;
   logic [31:0]     wdata_q, wdata_nxt;
   logic            wen_q, wen_nxt;
   logic            busy_nxt, run_nxt, fail_nxt;
   logic            in_ready;
   logic            hs;

`ifdef IMEM_LOADER_VERIFY_EN
   logic            ren_q, ren_nxt;
   logic            rd_pend;
   logic [31:0]     acc_q, acc_nxt;
`else
   logic            unused_rdata;
   assign unused_rdata = ^bus.rdata_ext;
`endif

   function automatic logic [31:0] word_addr(input logic [ADDR_W:0] i);
      return BASE_ADDR + (32'(i) << 2);
   endfunction

   assign in_ready = (state == S_LOAD);
   assign hs       = bus.in_valid && in_ready;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      len_nxt   = len;
      csum_nxt  = csum_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      wen_nxt   = 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
      ren_nxt   = 1'b0;
      acc_nxt   = rd_pend ? (acc_q ^ bus.rdata_ext) : acc_q;
`endif
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_RUN, S_FAIL: begin
               if (start) begin
                  idx_nxt  = '0;
                  csum_nxt = '0;
                  len_nxt  = num_words;
                  if (num_words == '0)
                     state_nxt = S_RUN;
                  else if (num_words > MAX_WORDS)
                     state_nxt = S_FAIL;
                  else
                     state_nxt = S_LOAD;
               end
            end
            S_LOAD: begin
               if (hs) begin
                  wen_nxt   = 1'b1;
                  addr_nxt  = word_addr(idx);
                  wdata_nxt = bus.in_data;
                  csum_nxt  = csum_q ^ bus.in_data;
                  idx_nxt   = idx + 1'b1;
                  if (idx + 1'b1 == len)
                     state_nxt = S_LOAD_END;
               end
            end
            S_LOAD_END: begin
`ifdef IMEM_LOADER_VERIFY_EN
               // First read issues here so reads run back-to-back from the first VERIFY cycle.
               state_nxt = S_VERIFY;
               ren_nxt   = 1'b1;
               addr_nxt  = word_addr('0);
               idx_nxt   = {{ADDR_W{1'b0}}, 1'b1};
               acc_nxt   = '0;
`else
               state_nxt = S_RUN;
`endif
            end
`ifdef IMEM_LOADER_VERIFY_EN
            S_VERIFY: begin
               if (idx < len) begin
                  ren_nxt  = 1'b1;
                  addr_nxt = word_addr(idx);
                  idx_nxt  = idx + 1'b1;
               end
               // The first cycle with no read in flight carries the last read data.
               if (!ren_q)
                  state_nxt = (acc_nxt == csum_q) ? S_RUN : S_FAIL;
            end
`endif
            default: state_nxt = S_IDLE;
         endcase
      end

      busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_LOAD_END)
`ifdef IMEM_LOADER_VERIFY_EN
               || (state_nxt == S_VERIFY)
`endif
               ;
      run_nxt  = (state_nxt == S_RUN);
      fail_nxt = (state_nxt == S_FAIL);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         len        <= '0;
         csum_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wen_q      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_enable <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         len        <= len_nxt;
         csum_q     <= csum_nxt;
         addr_q     <= addr_nxt;
         wdata_q    <= wdata_nxt;
         wen_q      <= wen_nxt;
         busy       <= busy_nxt;
         done       <= run_nxt;
         cpu_enable <= run_nxt;
         error      <= fail_nxt;
      end
   end

`ifdef IMEM_LOADER_VERIFY_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ren_q   <= 1'b0;
         rd_pend <= 1'b0;
         acc_q   <= '0;
      end else begin
         ren_q   <= ren_nxt;
         rd_pend <= ren_q;
         acc_q   <= acc_nxt;
      end
   end
   assign bus.ren_ext = ren_q;
`else
   assign bus.ren_ext = 1'b0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.addr_ext  = addr_q;
   assign bus.wen_ext   = wen_q;
   assign bus.wdata_ext = wdata_q;
   assign checksum      = csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a write-list / XOR reference model.
module tb_imem_loader;
   localparam int ADDR_W = 9;
   localparam int N_MAX  = 512;

   logic              clk = 1'b0;
   logic              arst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W:0]   num_words = '0;
   logic              cpu_enable, busy, done, error;
   logic [31:0]       checksum;

   imem_loader_if bus();

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .arst_n(arst_n), .start(start), .abort(abort), .num_words(num_words),
      .bus(bus.master), .cpu_enable(cpu_enable), .busy(busy), .done(done),
      .error(error), .checksum(checksum)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // memory model; word 5 can be corrupted on read
   logic [31:0] mem [0:N_MAX-1];
   bit          corrupt = 1'b0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.wen_ext) mem[bus.addr_ext[ADDR_W+1:2]] <= bus.wdata_ext;
      if (bus.ren_ext)
         bus.rdata_ext <= mem[bus.addr_ext[ADDR_W+1:2]] ^
                          ((corrupt && bus.addr_ext[ADDR_W+1:2] == 5) ? 32'h1 : 32'h0);
      else
         bus.rdata_ext <= 32'h0;
   end

   int          w_cyc[$];
   logic [31:0] w_addr[$];
   logic [31:0] w_dat[$];
   int          ren_cnt = 0;
   int          both_cnt = 0;
   always @(negedge clk) begin
      if (bus.wen_ext) begin
         w_cyc.push_back(cyc);
         w_addr.push_back(bus.addr_ext);
         w_dat.push_back(bus.wdata_ext);
      end
      if (bus.ren_ext) ren_cnt++;
      if (bus.ren_ext && bus.wen_ext) both_cnt++;
   end

   logic [31:0] words[$];
   int          hs_cyc[$];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_logs();
      w_cyc.delete(); w_addr.delete(); w_dat.delete();
      ren_cnt = 0;
   endtask

   task automatic pulse_start(input int n);
      logic [31:0] nv;
      nv = n;
      start = 1'b1;
      num_words = nv[ADDR_W:0];
      tick();
      start = 1'b0;
   endtask

   function automatic logic [31:0] model_xor();
      logic [31:0] x = 32'h0;
      foreach (words[k]) x ^= words[k];
      return x;
   endfunction

   // mode 0: no bubbles, 1: valid every other cycle, 2: random bubbles
   task automatic stream(input int mode);
      int k = 0;
      int phase = 0;
      hs_cyc.delete();
      while (k < words.size() && phase < 5000) begin
         if (mode == 0)      bus.in_valid = 1'b1;
         else if (mode == 1) bus.in_valid = (phase % 2 == 0);
         else                bus.in_valid = ($urandom_range(0, 2) != 0);
         bus.in_data = bus.in_valid ? words[k] : $urandom;
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) begin
            hs_cyc.push_back(cyc);
            k++;
         end
         tick();
         phase++;
      end
      bus.in_valid = 1'b0;
      vectors++;
      if (k != words.size()) begin
         miscompares++;
         $display("FAIL stream_timeout: accepted %0d words, expected %0d", k, words.size());
      end
   endtask

   task automatic wait_settled(input string name);
      int b = 0;
      @(negedge clk);
      while (!(done || error) && b < 2000) begin
         @(negedge clk);
         b++;
      end
      vectors++;
      if (b >= 2000) begin
         miscompares++;
         $display("FAIL %s_settle_timeout: done=%0b error=%0b after %0d cycles", name, done, error, b);
      end
      tick();
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
   endtask

   task automatic test_reset();
      #12;
      @(negedge clk);
      vectors++;
      if ({cpu_enable, busy, done, error, bus.wen_ext, bus.ren_ext, bus.in_ready} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 0000000",
                  {cpu_enable, busy, done, error, bus.wen_ext, bus.ren_ext, bus.in_ready});
      end
      vectors++;
      if (bus.addr_ext !== 32'h0 || checksum !== 32'h0 || bus.wdata_ext !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_buses: addr=%h csum=%h wdata=%h expected 0", bus.addr_ext, checksum, bus.wdata_ext);
      end
      tick();
      arst_n = 1'b1;
      tick();
      // reset in the middle of a load
      rand_words(4);
      pulse_start(4);
      bus.in_valid = 1'b1; bus.in_data = words[0]; tick();
      bus.in_data = words[1]; tick();
      #2 arst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      vectors++;
      if ({cpu_enable, busy, done, error, bus.wen_ext, bus.ren_ext, bus.in_ready} !== 7'b0
          || bus.addr_ext !== 32'h0 || checksum !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid_load: flags=%b addr=%h csum=%h expected all 0",
                  {cpu_enable, busy, done, error, bus.wen_ext, bus.ren_ext, bus.in_ready}, bus.addr_ext, checksum);
      end
      tick();
      arst_n = 1'b1;
      tick();
      clear_logs();
      rand_words(3);
      pulse_start(3);
      stream(0);
      wait_settled("reset_reload");
      vectors++;
      if (w_addr.size() != 3 || w_addr[0] !== 32'h0 || w_addr[1] !== 32'h4 || w_addr[2] !== 32'h8
          || w_dat[0] !== words[0] || w_dat[1] !== words[1] || w_dat[2] !== words[2]) begin
         miscompares++;
         $display("FAIL reset_reload_writes: %0d writes, first addr %h, expected 3 writes at 0,4,8",
                  w_addr.size(), (w_addr.size() > 0) ? w_addr[0] : 32'hx);
      end
   endtask

   task automatic test_basic(input int mode, input string name);
      int last;
      clear_logs();
      words.delete();
      words.push_back(32'h20080005); words.push_back(32'h20090003);
      words.push_back(32'h01095020); words.push_back(32'hAC0A0000);
      pulse_start(4);
      stream(mode);
      last = (hs_cyc.size() > 0) ? hs_cyc[hs_cyc.size()-1] : -1;
      @(negedge clk);
      vectors++;
      if (cpu_enable !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0 || cyc != last + 1) begin
         miscompares++;
         $display("FAIL %s_load_end: cpu_en=%0b busy=%0b in_ready=%0b cyc=%0d expected 0,1,0 at %0d",
                  name, cpu_enable, busy, bus.in_ready, cyc, last + 1);
      end
      tick();
      @(negedge clk);
      vectors++;
`ifdef IMEM_LOADER_VERIFY_EN
      if (cpu_enable !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_verify_entry: cpu_en=%0b busy=%0b expected 0,1", name, cpu_enable, busy);
      end
`else
      if (cpu_enable !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_run_entry: cpu_en=%0b done=%0b busy=%0b expected 1,1,0", name, cpu_enable, done, busy);
      end
`endif
      tick();
      wait_settled(name);
      vectors++;
      if (checksum !== model_xor() || done !== 1'b1 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_checksum: got %h done=%0b err=%0b expected %h,1,0", name, checksum, done, error, model_xor());
      end
      vectors++;
      if (w_addr.size() != 4) begin
         miscompares++;
         $display("FAIL %s_write_count: got %0d expected 4", name, w_addr.size());
      end
      for (int k = 0; k < 4 && k < w_addr.size(); k++) begin
         vectors++;
         if (w_addr[k] !== 32'(4 * k) || w_dat[k] !== words[k]
             || (k > 0 && w_cyc[k] - w_cyc[k-1] != mode + 1)) begin
            miscompares++;
            $display("FAIL %s_write%0d: addr=%h data=%h gap=%0d expected %h,%h,%0d", name, k, w_addr[k],
                     w_dat[k], (k > 0) ? w_cyc[k] - w_cyc[k-1] : 0, 32'(4 * k), words[k], mode + 1);
         end
      end
   endtask

   task automatic test_length();
      clear_logs();
      pulse_start(513);
      @(negedge clk);
      vectors++;
      if (error !== 1'b1 || cpu_enable !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL length_fail: err=%0b cpu_en=%0b busy=%0b in_ready=%0b expected 1,0,0,0",
                  error, cpu_enable, busy, bus.in_ready);
      end
      tick(); tick(); tick();
      vectors++;
      if (w_addr.size() != 0) begin
         miscompares++;
         $display("FAIL length_no_write: got %0d writes expected 0", w_addr.size());
      end
      pulse_start(0);
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || cpu_enable !== 1'b1 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL length_zero_run: done=%0b cpu_en=%0b err=%0b expected 1,1,0", done, cpu_enable, error);
      end
      tick();
      // largest legal image
      clear_logs();
      rand_words(N_MAX);
      pulse_start(N_MAX);
      stream(2);
      wait_settled("length_max");
      vectors++;
      if (checksum !== model_xor() || done !== 1'b1 || error !== 1'b0 || w_addr.size() != N_MAX) begin
         miscompares++;
         $display("FAIL length_max: csum=%h writes=%0d done=%0b err=%0b expected %h,%0d,1,0",
                  checksum, w_addr.size(), done, error, model_xor(), N_MAX);
      end
      vectors++;
      if (w_addr.size() == N_MAX && (w_addr[N_MAX-1] !== 32'h7FC || w_dat[N_MAX-1] !== words[N_MAX-1])) begin
         miscompares++;
         $display("FAIL length_max_last: addr=%h data=%h expected 000007fc,%h",
                  w_addr[N_MAX-1], w_dat[N_MAX-1], words[N_MAX-1]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int n;
         int bad;
         n = $urandom_range(1, 40);
         clear_logs();
         rand_words(n);
         pulse_start(n);
         stream(2);
         wait_settled("random");
         bad = 0;
         for (int k = 0; k < n && k < w_addr.size() && k < hs_cyc.size(); k++)
            if (w_addr[k] !== 32'(4 * k) || w_dat[k] !== words[k] || w_cyc[k] != hs_cyc[k] + 1) bad++;
         vectors++;
         if (bad != 0 || w_addr.size() != n || checksum !== model_xor() || done !== 1'b1) begin
            miscompares++;
            $display("FAIL random_load%0d: n=%0d writes=%0d bad=%0d csum=%h expected %h done=%0b",
                     it, n, w_addr.size(), bad, checksum, model_xor(), done);
         end
      end
   endtask

   task automatic test_abort();
      clear_logs();
      rand_words(4);
      pulse_start(4);
      bus.in_valid = 1'b1; bus.in_data = words[0]; tick();
      bus.in_data = words[1]; tick();
      abort = 1'b1;
      bus.in_data = words[2];
      tick();
      abort = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0 || cpu_enable !== 1'b0 || done !== 1'b0 || bus.wen_ext !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_idle: in_ready=%0b busy=%0b cpu_en=%0b done=%0b wen=%0b expected all 0",
                  bus.in_ready, busy, cpu_enable, done, bus.wen_ext);
      end
      tick(); tick(); tick();
      vectors++;
      if (w_addr.size() != 2 || (w_addr.size() == 2 && (w_addr[1] !== 32'h4 || w_dat[1] !== words[1]))) begin
         miscompares++;
         $display("FAIL abort_writes: got %0d writes expected 2 ending at 00000004", w_addr.size());
      end
      // abort beats a simultaneous start
      start = 1'b1; abort = 1'b1; num_words = 10'd2;
      tick();
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_vs_start: in_ready=%0b busy=%0b expected 0,0", bus.in_ready, busy);
      end
      tick();
   endtask

   task automatic test_verify();
`ifdef IMEM_LOADER_VERIFY_EN
      for (int pass = 0; pass < 2; pass++) begin
         corrupt = (pass == 0);
         clear_logs();
         rand_words(8);
         pulse_start(8);
         stream(0);
         wait_settled("verify");
         vectors++;
         if (ren_cnt != 8 || error !== corrupt || cpu_enable !== !corrupt || done !== !corrupt) begin
            miscompares++;
            $display("FAIL verify_corrupt%0d: reads=%0d err=%0b cpu_en=%0b expected 8,%0b,%0b",
                     pass, ren_cnt, error, cpu_enable, corrupt, !corrupt);
         end
      end
      corrupt = 1'b0;
`else
      vectors++;
      if (ren_cnt != 0) begin
         miscompares++;
         $display("FAIL no_verify_reads: got %0d read cycles expected 0", ren_cnt);
      end
`endif
      vectors++;
      if (both_cnt != 0) begin
         miscompares++;
         $display("FAIL wen_ren_overlap: got %0d cycles expected 0", both_cnt);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h0;
      test_reset();
      test_basic(0, "basic");
      test_basic(1, "bubbles");
      test_length();
      test_random();
      test_abort();
      test_verify();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
